stopwatch_uart_report: RTL and testbench



---
 rtl/stopwatch_pkg.sv | 33 +++
 rtl/uart_tx_byte.sv | 110 +++++++++++
 rtl/stopwatch_uart_report.sv | 103 ++++++++++
 tb/tb_stopwatch_uart_report.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch UART time reporter:
// serializer states, frame characters and the BCD-to-ASCII digit map.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam logic [7:0] CH_COLON = 8'h3A;
  localparam logic [7:0] CH_DOT   = 8'h2E;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;

  localparam int unsigned FRM_LEN  = 9;
  localparam logic [3:0]  CHR_LAST = 4'(FRM_LEN - 1);

  typedef struct packed {
    logic [3:0] min1;
    logic [3:0] min0;
    logic [3:0] sec1;
    logic [3:0] sec0;
    logic [3:0] mil2;
  } bcd_time_t;

  // Non-BCD nibbles print as 'A'..'F', the same way the hex displays show them.
  function automatic logic [7:0] bcd2ascii(input logic [3:0] d);
    return (d <= 4'd9) ? (8'h30 + {4'h0, d}) : (8'h37 + {4'h0, d});
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer, LSB first, BDN clocks per bit. rdy is also high in the
// last cycle of the stop bit so characters can be chained with no idle gap.
module uart_tx_byte
  import stopwatch_pkg::*;
#(
  parameter int unsigned BDN = 208
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vld,
  input  logic [7:0] dat,
  output logic       rdy,
  output logic       txd
);

  localparam int unsigned   CW      = $clog2(BDN);
  localparam logic [CW-1:0] CNT_TOP = CW'(BDN - 1);

  tx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shf_q, shf_d;
  logic          txd_q, txd_d;
  logic          cnt_done;

  assign cnt_done = (cnt_q == '0);
  assign rdy      = (state_q == ST_IDLE) || ((state_q == ST_STOP) && cnt_done);
  assign txd      = txd_q;

  always_comb begin
    // NOTE: every _d takes its _q value first, so no path through the case leaves a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shf_d   = shf_q;
    txd_d   = txd_q;

    case (state_q)
      ST_IDLE: begin
        if (vld) begin
          state_d = ST_START;
          cnt_d   = CNT_TOP;
          shf_d   = dat;
          txd_d   = 1'b0;
        end
      end
      ST_START: begin
        if (cnt_done) begin
          state_d = ST_DATA;
          cnt_d   = CNT_TOP;
          bit_d   = 3'd0;
          txd_d   = shf_q[0];
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DATA: begin
        if (cnt_done) begin
          cnt_d = CNT_TOP;
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
            txd_d   = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            shf_d = {1'b0, shf_q[7:1]};
            txd_d = shf_q[1];
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_STOP: begin
        if (cnt_done) begin
          if (vld) begin
            state_d = ST_START;
            cnt_d   = CNT_TOP;
            shf_d   = dat;
            txd_d   = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        txd_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignment so update order never matters.
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shf_q   <= '0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shf_q   <= shf_d;
      txd_q   <= txd_d;
    end
  end

endmodule

// File: rtl/stopwatch_uart_report.sv
// Snapshots the BCD stopwatch time on snd and sends "MM:SS.t\r\n" over UART.
// STOPWATCH_UART_AUTO_EN: any change of t_mil_2 also requests a frame.
module stopwatch_uart_report
  import stopwatch_pkg::*;
#(
  parameter int unsigned BDN = 208
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       snd,
  input  logic [3:0] t_mil_2,
  input  logic [3:0] t_sec_0,
  input  logic [3:0] t_sec_1,
  input  logic [3:0] t_min_0,
  input  logic [3:0] t_min_1,
  output logic       txd,
  output logic       bsy
);

  bcd_time_t  live, snap_q, snap_d;
  logic       bsy_q, bsy_d;
  logic [3:0] chr_q, chr_d;
  logic       req, accept;
  logic       tx_vld, tx_rdy;
  logic [7:0] tx_dat;

  assign live = '{min1: t_min_1, min0: t_min_0, sec1: t_sec_1, sec0: t_sec_0, mil2: t_mil_2};

`ifdef STOPWATCH_UART_AUTO_EN
  logic [3:0] prv_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prv_q <= 4'd0;
    else        prv_q <= t_mil_2;
  end

  assign req = snd | (t_mil_2 != prv_q);
`else
  assign req = snd;
`endif

  function automatic logic [7:0] frame_char(input logic [3:0] idx, input bcd_time_t s);
    logic [7:0] c;
    case (idx)
      4'd0:    c = bcd2ascii(s.min1);
      4'd1:    c = bcd2ascii(s.min0);
      4'd2:    c = CH_COLON;
      4'd3:    c = bcd2ascii(s.sec1);
      4'd4:    c = bcd2ascii(s.sec0);
      4'd5:    c = CH_DOT;
      4'd6:    c = bcd2ascii(s.mil2);
      4'd7:    c = CH_CR;
      default: c = CH_LF;
    endcase
    return c;
  endfunction

  // The first character comes straight from the live digits so its start bit
  // can go out the cycle after acceptance; the rest come from the snapshot.
  always_comb begin
    accept = req & ~bsy_q;
    snap_d = accept ? live : snap_q;
    tx_vld = accept | (bsy_q & (chr_q < CHR_LAST));
    tx_dat = frame_char(accept ? 4'd0 : (chr_q + 4'd1), snap_d);

    bsy_d = bsy_q;
    chr_d = chr_q;
    if (accept) begin
      bsy_d = 1'b1;
      chr_d = 4'd0;
    end else if (bsy_q && tx_rdy) begin
      if (chr_q == CHR_LAST) bsy_d = 1'b0;
      else                   chr_d = chr_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the snapshot is a few flops, not a memory, so clearing it on reset is cheap.
    if (!rst_n) begin
      snap_q <= '0;
      bsy_q  <= 1'b0;
      chr_q  <= 4'd0;
    end else begin
      snap_q <= snap_d;
      bsy_q  <= bsy_d;
      chr_q  <= chr_d;
    end
  end

  uart_tx_byte #(
    .BDN (BDN)
  ) u_tx (
    .clk   (clk),
    .rst_n (rst_n),
    .vld   (tx_vld),
    .dat   (tx_dat),
    .rdy   (tx_rdy),
    .txd   (txd)
  );

  assign bsy = bsy_q;

endmodule

// File: tb/tb_stopwatch_uart_report.sv
// Scoreboard bench: expected frame bytes are queued when a request is driven
// and compared against bytes recovered by a UART receiver on txd.
module tb_stopwatch_uart_report;

  localparam int unsigned BDN  = 4;
  localparam int unsigned FLEN = 90 * BDN;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       snd = 1'b0;
  logic [3:0] t_mil_2 = 4'd0;
  logic [3:0] t_sec_0 = 4'd0;
  logic [3:0] t_sec_1 = 4'd0;
  logic [3:0] t_min_0 = 4'd0;
  logic [3:0] t_min_1 = 4'd0;
  logic       txd;
  logic       bsy;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  int run_len  = 0;
  int last_len = 0;

  stopwatch_uart_report #(.BDN(BDN)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .snd     (snd),
    .t_mil_2 (t_mil_2),
    .t_sec_0 (t_sec_0),
    .t_sec_1 (t_sec_1),
    .t_min_0 (t_min_0),
    .t_min_1 (t_min_1),
    .txd     (txd),
    .bsy     (bsy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] asc(input logic [3:0] d);
    string hexd = "0123456789ABCDEF";
    return hexd[d];
  endfunction

  task automatic push_frame(input logic [3:0] m1, m0, s1, s0, t);
    exp_q.push_back(asc(m1));
    exp_q.push_back(asc(m0));
    exp_q.push_back(8'h3A);
    exp_q.push_back(asc(s1));
    exp_q.push_back(asc(s0));
    exp_q.push_back(8'h2E);
    exp_q.push_back(asc(t));
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  // Busy-run length monitor; last_len is valid one negedge after bsy falls.
  always @(negedge clk) begin
    if (rst_n !== 1'b1)  run_len <= 0;
    else if (bsy === 1'b1) run_len <= run_len + 1;
    else if (run_len != 0) begin
      last_len <= run_len;
      run_len  <= 0;
    end
  end

  task automatic rx_wait(input int n, inout bit ok);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (rst_n !== 1'b1) ok = 1'b0;
    end
  endtask

  initial begin : rx
    logic [7:0] b;
    bit ok;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && txd === 1'b0) begin
        ok = 1'b1;
        b  = 8'h00;
        rx_wait(BDN / 2, ok);
        for (int i = 0; i < 8; i++) begin
          rx_wait(BDN, ok);
          b[i] = txd;
        end
        rx_wait(BDN, ok);
        if (ok) begin
          check("stop_bit", txd, 1);
          check("byte_pending", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) check("rx_byte", b, exp_q.pop_front());
        end
      end
    end
  end

  // Drives a request one cycle, then checks the start bit appears next cycle.
  task automatic fire(input logic [3:0] m1, m0, s1, s0, t, input logic use_snd);
    @(negedge clk);
    check("pre_txd", txd, 1);
    check("pre_bsy", bsy, 0);
    t_min_1 = m1; t_min_0 = m0; t_sec_1 = s1; t_sec_0 = s0; t_mil_2 = t;
    snd = use_snd;
    push_frame(m1, m0, s1, s0, t);
    @(negedge clk);
    snd = 1'b0;
    check("start_bsy", bsy, 1);
    check("start_txd", txd, 0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bsy !== 1'b0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("frame_end_in_time", n < 5000, 1);
    @(negedge clk);
    check("bsy_len", last_len, FLEN);
  endtask

  task automatic quiet(input int n, input string tag);
    int bad = 0;
    repeat (n) begin
      @(negedge clk);
      if (txd !== 1'b1 || bsy !== 1'b0) bad++;
    end
    check(tag, bad, 0);
  endtask

  initial begin : stim
    int n;
    repeat (3) @(negedge clk);
    check("rst_txd", txd, 1);
    check("rst_bsy", bsy, 0);
    rst_n = 1'b1;
    quiet(1000, "idle_quiet");

`ifdef STOPWATCH_UART_AUTO_EN
    t_min_1 = 4'd1; t_min_0 = 4'd2; t_sec_1 = 4'd3; t_sec_0 = 4'd4;
    fire(4'd1, 4'd2, 4'd3, 4'd4, 4'd1, 1'b0);
    wait_idle();
    repeat (1000 - FLEN - 3) @(negedge clk);
    fire(4'd1, 4'd2, 4'd3, 4'd4, 4'd2, 1'b0);
    repeat (100) @(negedge clk);
    t_mil_2 = 4'd3;
    wait_idle();
    quiet(500, "auto_step_in_busy_dropped");
`else
    // 12:34.5, then inputs move mid-frame; the frame must carry the snapshot.
    fire(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 1'b1);
    repeat (50) @(negedge clk);
    t_min_1 = 4'd5; t_min_0 = 4'd9; t_sec_1 = 4'd5; t_sec_0 = 4'd9; t_mil_2 = 4'd9;
    wait_idle();

    // snd held through the whole frame: only one frame, then an immediate second.
    fire(4'd0, 4'd7, 4'd4, 4'd2, 4'd8, 1'b1);
    snd = 1'b1;
    t_min_1 = 4'd9; t_min_0 = 4'd9; t_sec_1 = 4'd9; t_sec_0 = 4'd9; t_mil_2 = 4'd9;
    n = 0;
    while (bsy !== 1'b0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("held_snd_end_in_time", n < 5000, 1);
    t_min_1 = 4'hA; t_min_0 = 4'd0; t_sec_1 = 4'd0; t_sec_0 = 4'd0; t_mil_2 = 4'd1;
    push_frame(4'hA, 4'd0, 4'd0, 4'd0, 4'd1);
    @(negedge clk);
    snd = 1'b0;
    check("b2b_bsy", bsy, 1);
    check("b2b_txd", txd, 0);
    check("held_snd_len", last_len, FLEN);

    // Reset in the middle of the 4th character.
    repeat (30 * BDN + 6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_txd", txd, 1);
    check("async_rst_bsy", bsy, 0);
    check("rst_dropped_bytes", exp_q.size(), 6);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    quiet(200, "no_resume_after_rst");

    fire(4'd0, 4'hF, 4'd0, 4'd9, 4'd0, 1'b1);
    wait_idle();
`endif

    repeat (20) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
